// File: rtl/mips_instr_encoder.sv
// Streaming MIPS instruction encoder. Packs one mnemonic and its operand
// fields per handshake into a 32-bit instruction word and queues it in a
// small FIFO. Words leave the FIFO tagged with consecutive byte addresses.
module mips_instr_encoder #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_mnem,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_shamt,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic [31:0] out_addr,
  output logic        err_illegal,
  output logic [7:0]  illegal_cnt,
  output logic [15:0] word_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Mnemonic indices whose field handling differs from the plain pattern.
  localparam logic [4:0] M_SLL     = 5'd10;
  localparam logic [4:0] M_SRA     = 5'd12;
  localparam logic [4:0] M_JR      = 5'd14;
  localparam logic [4:0] M_SYSCALL = 5'd15;
  localparam logic [4:0] M_J       = 5'd16;
  localparam logic [4:0] M_JAL     = 5'd17;
  localparam logic [4:0] M_BLTZ    = 5'd28;

  logic [31:0]   r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_addr;
  logic          r_err;
  logic [7:0]    r_ill_cnt;
  logic [15:0]   r_word_cnt;

  logic        w_legal;
  logic        w_accept;
  logic        w_wr;
  logic        w_pop;
  logic [31:0] w_word;
  logic [5:0]  w_op;
  logic [5:0]  w_funct;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [4:0]  w_sh;

  assign w_legal   = (in_mnem <= M_BLTZ);
  assign in_ready  = (r_count < DEPTH_C);
  assign out_valid = (r_count != '0);
  assign out_word  = out_valid ? r_mem[r_rptr] : 32'h0;
  assign out_addr  = r_addr;
  assign err_illegal = r_err;
  assign illegal_cnt = r_ill_cnt;
  assign word_cnt    = r_word_cnt;

  // Handshakes in a clr cycle are dropped; illegal mnemonics never reach the FIFO.
  assign w_accept = in_valid & in_ready & ~clr;
  assign w_wr     = w_accept & w_legal;
  assign w_pop    = out_valid & out_ready & ~clr;

  // Instruction packing with per-mnemonic field forcing.
  always_comb begin
    w_word  = 32'h0;
    w_op    = 6'h00;
    w_funct = 6'h00;
    w_rs    = in_rs;
    w_rt    = in_rt;
    w_rd    = in_rd;
    w_sh    = 5'h00;
    if (in_mnem < M_J) begin
      case (in_mnem[3:0])
        4'd0:    w_funct = 6'h20;
        4'd1:    w_funct = 6'h21;
        4'd2:    w_funct = 6'h22;
        4'd3:    w_funct = 6'h23;
        4'd4:    w_funct = 6'h24;
        4'd5:    w_funct = 6'h25;
        4'd6:    w_funct = 6'h26;
        4'd7:    w_funct = 6'h27;
        4'd8:    w_funct = 6'h2A;
        4'd9:    w_funct = 6'h2B;
        4'd10:   w_funct = 6'h00;
        4'd11:   w_funct = 6'h02;
        4'd12:   w_funct = 6'h03;
        4'd13:   w_funct = 6'h04;
        4'd14:   w_funct = 6'h08;
        default: w_funct = 6'h0C;
      endcase
      if (in_mnem >= M_SLL && in_mnem <= M_SRA) begin
        w_sh = in_shamt;
        w_rs = 5'h00;
      end
      if (in_mnem == M_JR) begin
        w_rt = 5'h00;
        w_rd = 5'h00;
      end
      if (in_mnem == M_SYSCALL) begin
        w_rs = 5'h00;
        w_rt = 5'h00;
        w_rd = 5'h00;
      end
      w_word = {6'h00, w_rs, w_rt, w_rd, w_sh, w_funct};
    end else if (in_mnem <= M_JAL) begin
      w_op   = (in_mnem == M_JAL) ? 6'h03 : 6'h02;
      w_word = {w_op, in_target};
    end else if (w_legal) begin
      case (in_mnem)
        5'd18:   w_op = 6'h04;
        5'd19:   w_op = 6'h05;
        5'd20:   w_op = 6'h08;
        5'd21:   w_op = 6'h09;
        5'd22:   w_op = 6'h0A;
        5'd23:   w_op = 6'h0C;
        5'd24:   w_op = 6'h0D;
        5'd25:   w_op = 6'h23;
        5'd26:   w_op = 6'h2B;
        5'd27:   w_op = 6'h20;
        default: w_op = 6'h01;
      endcase
      if (in_mnem == M_BLTZ) w_rt = 5'h00;
      w_word = {w_op, w_rs, w_rt, in_imm};
    end
  end

  // FIFO storage; contents are only meaningful where count says so, so no reset.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= w_word;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr)  r_wptr <= r_wptr + PW'(1);
      if (w_pop) r_rptr <= r_rptr + PW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Output address and emitted-word counter advance on each pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= BASE_ADDR;
      r_word_cnt <= '0;
    end else if (clr) begin
      r_addr     <= BASE_ADDR;
      r_word_cnt <= '0;
    end else if (w_pop) begin
      r_addr     <= r_addr + 32'd4;
      r_word_cnt <= r_word_cnt + 16'd1;
    end
  end

  // Sticky illegal-mnemonic flag and saturating count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err     <= 1'b0;
      r_ill_cnt <= '0;
    end else if (clr) begin
      r_err     <= 1'b0;
      r_ill_cnt <= '0;
    end else if (w_accept && !w_legal) begin
      r_err <= 1'b1;
      if (r_ill_cnt != 8'hFF) r_ill_cnt <= r_ill_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Bench for the MIPS instruction encoder: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_mips_instr_encoder;

  localparam logic [31:0] BASE = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_mnem = '0;
  logic [4:0]  in_rs = '0;
  logic [4:0]  in_rt = '0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_shamt = '0;
  logic [15:0] in_imm = '0;
  logic [25:0] in_target = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_word;
  logic [31:0] out_addr;
  logic        err_illegal;
  logic [7:0]  illegal_cnt;
  logic [15:0] word_cnt;

  int total = 0;
  int bad = 0;

  mips_instr_encoder #(.DEPTH(4), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_imm(in_imm), .in_target(in_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_addr(out_addr),
    .err_illegal(err_illegal), .illegal_cnt(illegal_cnt), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  // Reference encoding built from the instruction format tables.
  function automatic logic [31:0] ref_enc(int m, logic [4:0] rs, logic [4:0] rt,
                                          logic [4:0] rd, logic [4:0] sh,
                                          logic [15:0] imm, logic [25:0] tgt);
    int rfun [16] = '{'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'h27,
                      'h2A, 'h2B, 'h00, 'h02, 'h03, 'h04, 'h08, 'h0C};
    int iop [11] = '{'h04, 'h05, 'h08, 'h09, 'h0A, 'h0C, 'h0D, 'h23, 'h2B, 'h20, 'h01};
    logic [31:0] w;
    if (m < 16) begin
      bit is_shift = (m == 10 || m == 11 || m == 12);
      logic [31:0] r_s = is_shift ? 0 : rs;
      logic [31:0] r_t = rt;
      logic [31:0] r_d = rd;
      logic [31:0] s_a = is_shift ? sh : 0;
      if (m == 14) begin r_t = 0; r_d = 0; end
      if (m == 15) begin r_s = 0; r_t = 0; r_d = 0; s_a = 0; end
      w = r_s * 32'h0020_0000 + r_t * 32'h0001_0000 + r_d * 32'h800 + s_a * 64 + rfun[m];
    end else if (m < 18) begin
      w = 32'(m - 14) * 32'h0400_0000 + 32'(tgt);
    end else begin
      logic [31:0] r_t = (m == 28) ? 0 : rt;
      w = 32'(iop[m-18]) * 32'h0400_0000 + 32'(rs) * 32'h0020_0000 + r_t * 32'h0001_0000 + 32'(imm);
    end
    return w;
  endfunction

  task automatic set_in(int m, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                        logic [4:0] sh, logic [15:0] imm, logic [25:0] tgt);
    in_valid = 1'b1;
    in_mnem = 5'(m); in_rs = rs; in_rt = rt; in_rd = rd;
    in_shamt = sh; in_imm = imm; in_target = tgt;
  endtask

  task automatic set_rand(int m);
    set_in(m, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
           16'($urandom), 26'($urandom));
  endtask

  task automatic cur_enc(output logic [31:0] w);
    w = ref_enc(int'(in_mnem), in_rs, in_rt, in_rd, in_shamt, in_imm, in_target);
  endtask

  task automatic pulse_clr();
    in_valid = 1'b0; out_ready = 1'b0; clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (out_word !== 32'h0) begin bad++; $display("FAIL reset_out_word got=%h exp=0", out_word); end
    total++; if (out_addr !== BASE) begin bad++; $display("FAIL reset_out_addr got=%h exp=%h", out_addr, BASE); end
    total++; if (err_illegal !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err_illegal); end
    total++; if (illegal_cnt !== 8'd0) begin bad++; $display("FAIL reset_ill_cnt got=%0d exp=0", illegal_cnt); end
    total++; if (word_cnt !== 16'd0) begin bad++; $display("FAIL reset_word_cnt got=%0d exp=0", word_cnt); end
  endtask

  task automatic test_basic();
    out_ready = 1'b0;
    set_in(0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
    total++; if (out_word !== 32'h0022_1820) begin bad++; $display("FAIL basic_word got=%h exp=00221820", out_word); end
    total++; if (out_addr !== 32'h0000_3000) begin bad++; $display("FAIL basic_addr got=%h exp=00003000", out_addr); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++; if (out_addr !== 32'h0000_3004) begin bad++; $display("FAIL basic_addr_next got=%h exp=00003004", out_addr); end
    total++; if (word_cnt !== 16'd1) begin bad++; $display("FAIL basic_word_cnt got=%0d exp=1", word_cnt); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_sequence();
    logic [31:0] exp_w [4] = '{32'h2008_FFFF, 32'h0800_0C00, 32'h0480_0003, 32'h0000_000C};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: set_in(20, 5'd0, 5'd8, 5'd0, 5'd0, 16'hFFFF, 26'h0);
        1: set_in(16, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000C00);
        2: set_in(28, 5'd4, 5'd7, 5'd0, 5'd0, 16'h0003, 26'h0);
        default: set_in(15, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 16'hFFFF, 26'h3FFFFFF);
      endcase
      @(negedge clk);
      total++; if (out_word !== exp_w[i]) begin bad++; $display("FAIL seq_word%0d got=%h exp=%h", i, out_word, exp_w[i]); end
      total++; if (out_addr !== 32'h3004 + 32'(4 * i)) begin bad++; $display("FAIL seq_addr%0d got=%h exp=%h", i, out_addr, 32'h3004 + 32'(4 * i)); end
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL seq_drained got=%b exp=0", out_valid); end
    total++; if (word_cnt !== 16'd5) begin bad++; $display("FAIL seq_word_cnt got=%0d exp=5", word_cnt); end
    total++; if (out_addr !== 32'h0000_3014) begin bad++; $display("FAIL seq_addr_end got=%h exp=00003014", out_addr); end
  endtask

  task automatic test_full();
    logic [31:0] w [4];
    pulse_clr();
    for (int i = 0; i < 4; i++) begin
      set_rand(int'($urandom_range(0, 28)));
      cur_enc(w[i]);
      @(negedge clk);
    end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
    set_rand(3);
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (out_word !== w[0]) begin bad++; $display("FAIL full_head got=%h exp=%h", out_word, w[0]); end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_ready_same_cycle got=%b exp=0", in_ready); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) begin
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL full_space got=%b exp=1", in_ready); end
      end
      if (i < 3) begin
        total++; if (out_word !== w[i+1]) begin bad++; $display("FAIL full_order%0d got=%h exp=%h", i + 1, out_word, w[i+1]); end
        total++; if (out_addr !== BASE + 32'(4 * (i + 1))) begin bad++; $display("FAIL full_addr%0d got=%h exp=%h", i + 1, out_addr, BASE + 32'(4 * (i + 1))); end
      end
    end
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL full_no_fifth got=%b exp=0", out_valid); end
    total++; if (word_cnt !== 16'd4) begin bad++; $display("FAIL full_word_cnt got=%0d exp=4", word_cnt); end
  endtask

  task automatic test_illegal();
    pulse_clr();
    set_rand(30);
    @(negedge clk);
    total++; if (err_illegal !== 1'b1) begin bad++; $display("FAIL ill_err got=%b exp=1", err_illegal); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ill_not_queued got=%b exp=0", out_valid); end
    set_in(24, 5'd0, 5'd9, 5'd0, 5'd0, 16'h1234, 26'h0);
    @(negedge clk);
    in_valid = 1'b0;
    total++; if (out_word !== 32'h3409_1234) begin bad++; $display("FAIL ill_ori got=%h exp=34091234", out_word); end
    total++; if (illegal_cnt !== 8'd1) begin bad++; $display("FAIL ill_cnt got=%0d exp=1", illegal_cnt); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ill_only_one got=%b exp=0", out_valid); end
    total++; if (word_cnt !== 16'd1) begin bad++; $display("FAIL ill_word_cnt got=%0d exp=1", word_cnt); end
    pulse_clr();
    total++; if (err_illegal !== 1'b0) begin bad++; $display("FAIL clr_err got=%b exp=0", err_illegal); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL clr_valid got=%b exp=0", out_valid); end
    total++; if (out_addr !== BASE) begin bad++; $display("FAIL clr_addr got=%h exp=%h", out_addr, BASE); end
    total++; if (word_cnt !== 16'd0) begin bad++; $display("FAIL clr_word_cnt got=%0d exp=0", word_cnt); end
    for (int i = 0; i < 260; i++) begin
      set_rand(int'($urandom_range(29, 31)));
      @(negedge clk);
    end
    in_valid = 1'b0;
    total++; if (illegal_cnt !== 8'd255) begin bad++; $display("FAIL ill_saturate got=%0d exp=255", illegal_cnt); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL ill_ready got=%b exp=1", in_ready); end
    pulse_clr();
    total++; if (illegal_cnt !== 8'd0) begin bad++; $display("FAIL clr_ill_cnt got=%0d exp=0", illegal_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q [$];
    logic [31:0] w;
    logic [31:0] a;
    pulse_clr();
    a = BASE;
    for (int i = 0; i < 2; i++) begin
      set_rand(int'($urandom_range(0, 28)));
      cur_enc(w); q.push_back(w);
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      total++; if (out_word !== q[0]) begin bad++; $display("FAIL b2b_word%0d got=%h exp=%h", i, out_word, q[0]); end
      total++; if (out_addr !== a) begin bad++; $display("FAIL b2b_addr%0d got=%h exp=%h", i, out_addr, a); end
      if (i < 10) begin
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready%0d got=%b exp=1", i, in_ready); end
        set_rand(int'($urandom_range(0, 28)));
        cur_enc(w); q.push_back(w);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      void'(q.pop_front());
      a += 4;
      if (i == 9) begin
        total++; if (word_cnt !== 16'd10) begin bad++; $display("FAIL b2b_word_cnt got=%0d exp=10", word_cnt); end
      end
    end
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drained got=%b exp=0", out_valid); end
  endtask

  task automatic test_random();
    logic [31:0] q [$];
    logic [31:0] a = BASE;
    logic [31:0] w;
    logic [31:0] head;
    bit e = 1'b0;
    int ic = 0;
    int wc = 0;
    int m;
    bit do_clr;
    pulse_clr();
    for (int c = 0; c < 400; c++) begin
      head = (q.size() != 0) ? q[0] : 32'h0;
      total++; if (out_valid !== (q.size() != 0)) begin bad++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, out_valid, q.size() != 0); end
      total++; if (out_word !== head) begin bad++; $display("FAIL rnd_word c=%0d got=%h exp=%h", c, out_word, head); end
      total++; if (out_addr !== a) begin bad++; $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, out_addr, a); end
      total++; if (in_ready !== (q.size() < 4)) begin bad++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, in_ready, q.size() < 4); end
      total++; if (err_illegal !== e || illegal_cnt !== 8'(ic)) begin bad++; $display("FAIL rnd_illegal c=%0d got=%b/%0d exp=%b/%0d", c, err_illegal, illegal_cnt, e, ic); end
      total++; if (word_cnt !== 16'(wc)) begin bad++; $display("FAIL rnd_word_cnt c=%0d got=%0d exp=%0d", c, word_cnt, wc); end
      m = ($urandom_range(0, 9) == 0) ? int'($urandom_range(29, 31)) : int'($urandom_range(0, 28));
      set_rand(m);
      in_valid = 1'($urandom_range(0, 2) != 0);
      out_ready = 1'($urandom_range(0, 2) == 0);
      do_clr = ($urandom_range(0, 59) == 0);
      clr = do_clr;
      cur_enc(w);
      if (do_clr) begin
        q.delete(); a = BASE; e = 1'b0; ic = 0; wc = 0;
      end else begin
        if (out_ready && q.size() != 0) begin
          void'(q.pop_front()); a += 4; wc++;
        end
        if (in_valid && in_ready) begin
          if (m >= 29) begin
            e = 1'b1; if (ic < 255) ic++;
          end else begin
            q.push_back(w);
          end
        end
      end
      @(negedge clk);
      clr = 1'b0;
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    pulse_clr();
    for (int i = 0; i < 4; i++) begin
      set_rand(int'($urandom_range(0, 28)));
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++; if (word_cnt !== 16'd1 || out_valid !== 1'b1) begin bad++; $display("FAIL arst_setup got=%0d/%b exp=1/1", word_cnt, out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b exp=0", out_valid); end
    total++; if (out_addr !== BASE) begin bad++; $display("FAIL arst_addr got=%h exp=%h", out_addr, BASE); end
    total++; if (out_word !== 32'h0) begin bad++; $display("FAIL arst_word got=%h exp=0", out_word); end
    total++; if (word_cnt !== 16'd0 || in_ready !== 1'b1) begin bad++; $display("FAIL arst_cnt_ready got=%0d/%b exp=0/1", word_cnt, in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_after got=%b exp=0", out_valid); end
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_sequence();
    test_full();
    test_illegal();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
